// File: rtl/data_source_dds.sv
// data_source_dds: N-channel phase-accumulator waveform source (sine/DC/ramp/square) with gain and valid/ready output.
// Rev 1.0
`default_nettype none

module data_source_dds #(
  parameter int N_CH     = 2,
  parameter int PHASE_W  = 32,
  parameter int LUT_AW   = 11,
  parameter int DATA_W   = 14,
  parameter int DC_LEVEL = 8192,
  parameter int DELAY    = 0
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      CE,
  input  logic                      sync_rst,
  input  logic [PHASE_W-1:0]        phase_inc,
  input  logic [N_CH*PHASE_W-1:0]   phase_off,
  input  logic [1:0]                mode,
  input  logic [15:0]               amplitude,
  input  logic                      ready,
  output logic                      data_valid,
  output logic [N_CH*32-1:0]        data,
  output logic                      zero_cross
);

  localparam int PH_KEEP = (DATA_W > LUT_AW) ? DATA_W : LUT_AW;
  localparam int PRE_W   = (DELAY > 0) ? $clog2(DELAY + 1) : 1;
  localparam int P_W     = DATA_W + 18;
  localparam int LUT_N   = 1 << LUT_AW;

  localparam logic signed [DATA_W:0]  C_DC_S  = (DATA_W + 1)'(DC_LEVEL);
  localparam logic signed [P_W-1:0]   C_DC_P  = P_W'(DC_LEVEL);
  localparam logic signed [P_W-1:0]   C_MAX_P = P_W'((1 << DATA_W) - 1);

  // Quarter-wave Taylor series in Q30 fixed point, mirrored to a full cycle.
  function automatic logic [DATA_W-1:0] sine_code(input int idx);
    longint half_n, quarter, j, q, x, x2, term, sum, mag, mid;
    half_n  = longint'(1) << (LUT_AW - 1);
    quarter = half_n >> 1;
    mid     = longint'(1) << (DATA_W - 1);
    j       = longint'(idx) % half_n;
    q       = (j <= quarter) ? j : half_n - j;
    x       = (64'sd3373259426 * q) / (2 * quarter);
    x2      = (x * x) >>> 30;
    term    = x;
    sum     = x;
    for (int k = 1; k <= 6; k++) begin
      term = -(((term * x2) >>> 30) / longint'(2 * k * (2 * k + 1)));
      sum  = sum + term;
    end
    mag = ((mid - 1) * sum + (longint'(1) << 29)) >>> 30;
    if (longint'(idx) >= half_n) begin
      return DATA_W'(mid - mag);
    end
    return DATA_W'(mid + mag);
  endfunction

  logic [DATA_W-1:0] lut_w [LUT_N];

  for (genvar i = 0; i < LUT_N; i++) begin : g_lut
    localparam logic [DATA_W-1:0] C_CODE = sine_code(i);
    assign lut_w[i] = C_CODE;
  end

  logic [PHASE_W-1:0] acc_q;
  logic [PRE_W-1:0]   pre_q;
  logic               first_q, carry_q;
  logic               v0_q, v1_q, wrap0_q, wrap1_q;
  logic [1:0]         mode0_q;
  logic [15:0]        amp0_q, amp1_q;
  logic [PH_KEEP-1:0] ph0_q  [N_CH];
  logic [DATA_W-1:0]  raw1_q [N_CH];
  logic [DATA_W-1:0]  out_q  [N_CH];
  logic               data_valid_q, zero_cross_q;

  logic               stall, tick;
  logic [PHASE_W:0]   acc_sum;
  logic [PH_KEEP-1:0] ph_d  [N_CH];
  logic [DATA_W-1:0]  raw_d [N_CH];
  logic [DATA_W-1:0]  y_d   [N_CH];
  logic signed [DATA_W:0] diff_w   [N_CH];
  logic signed [P_W-1:0]  scaled_w [N_CH];
  logic signed [P_W-1:0]  level_w  [N_CH];

  assign stall   = data_valid_q & ~ready;
  assign tick    = CE & ~stall & (pre_q == PRE_W'(DELAY));
  assign acc_sum = {1'b0, acc_q} + {1'b0, phase_inc};

  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      ph_d[k] = PH_KEEP'((acc_q + phase_off[k*PHASE_W +: PHASE_W]) >> (PHASE_W - PH_KEEP));
      case (mode0_q)
        2'd0:    raw_d[k] = lut_w[ph0_q[k][PH_KEEP-1 -: LUT_AW]];
        2'd1:    raw_d[k] = DATA_W'(DC_LEVEL);
        2'd2:    raw_d[k] = ph0_q[k][PH_KEEP-1 -: DATA_W];
        default: raw_d[k] = ph0_q[k][PH_KEEP-1] ? '0 : '1;
      endcase
      // Gain is Q1.15 around mid-scale; >>> floors negative products.
      diff_w[k]   = $signed({1'b0, raw1_q[k]}) - C_DC_S;
      scaled_w[k] = (P_W'(diff_w[k]) * P_W'($signed({1'b0, amp1_q}))) >>> 15;
      level_w[k]  = scaled_w[k] + C_DC_P;
      if (level_w[k] < 0) begin
        y_d[k] = '0;
      end else if (level_w[k] > C_MAX_P) begin
        y_d[k] = '1;
      end else begin
        y_d[k] = level_w[k][DATA_W-1:0];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_q        <= '0;
      pre_q        <= '0;
      first_q      <= 1'b1;
      carry_q      <= 1'b0;
      v0_q         <= 1'b0;
      v1_q         <= 1'b0;
      wrap0_q      <= 1'b0;
      wrap1_q      <= 1'b0;
      mode0_q      <= '0;
      amp0_q       <= '0;
      amp1_q       <= '0;
      data_valid_q <= 1'b0;
      zero_cross_q <= 1'b0;
      for (int k = 0; k < N_CH; k++) begin
        ph0_q[k]  <= '0;
        raw1_q[k] <= '0;
        out_q[k]  <= '0;
      end
    end else if (sync_rst) begin
      acc_q        <= '0;
      pre_q        <= '0;
      first_q      <= 1'b1;
      carry_q      <= 1'b0;
      v0_q         <= 1'b0;
      v1_q         <= 1'b0;
      data_valid_q <= 1'b0;
      zero_cross_q <= 1'b0;
    end else begin
      if (tick) begin
        pre_q   <= '0;
        acc_q   <= acc_sum[PHASE_W-1:0];
        carry_q <= acc_sum[PHASE_W];
        first_q <= 1'b0;
        wrap0_q <= carry_q | first_q;
        mode0_q <= mode;
        amp0_q  <= amplitude;
        for (int k = 0; k < N_CH; k++) begin
          ph0_q[k] <= ph_d[k];
        end
      end else if (CE && !stall) begin
        pre_q <= pre_q + 1'b1;
      end
      if (!stall) begin
        v0_q         <= tick;
        v1_q         <= v0_q;
        wrap1_q      <= wrap0_q;
        amp1_q       <= amp0_q;
        data_valid_q <= v1_q;
        zero_cross_q <= v1_q & wrap1_q;
        for (int k = 0; k < N_CH; k++) begin
          raw1_q[k] <= raw_d[k];
          if (v1_q) begin
            out_q[k] <= y_d[k];
          end
        end
      end
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_out
    assign data[k*32 +: 32] = 32'(out_q[k]);
  end

  assign data_valid = data_valid_q;
  assign zero_cross = zero_cross_q;

endmodule

`default_nettype wire

// File: tb/tb_data_source_dds.sv
// tb_data_source_dds: directed vector bench for data_source_dds (DELAY=0 and DELAY=3 instances).
// Rev 1.0
`default_nettype none

module tb_data_source_dds;

  logic        clock     = 1'b0;
  logic        reset_n   = 1'b1;
  logic        CE        = 1'b0;
  logic        sync_rst  = 1'b0;
  logic        ready     = 1'b1;
  logic [31:0] phase_inc = '0;
  logic [63:0] phase_off = '0;
  logic [1:0]  mode      = '0;
  logic [15:0] amplitude = 16'h8000;

  logic        dv0, zc0, dv3, zc3;
  logic [63:0] d0, d3;

  always #5 clock = ~clock;

  data_source_dds u_dut0 (
    .clock(clock), .reset_n(reset_n), .CE(CE), .sync_rst(sync_rst),
    .phase_inc(phase_inc), .phase_off(phase_off), .mode(mode), .amplitude(amplitude),
    .ready(ready), .data_valid(dv0), .data(d0), .zero_cross(zc0)
  );

  data_source_dds #(.DELAY(3)) u_dut3 (
    .clock(clock), .reset_n(reset_n), .CE(CE), .sync_rst(sync_rst),
    .phase_inc(phase_inc), .phase_off(phase_off), .mode(mode), .amplitude(amplitude),
    .ready(ready), .data_valid(dv3), .data(d3), .zero_cross(zc3)
  );

  int     checks = 0;
  int     errors = 0;
  longint cyc    = 0;

  int     n0 = 0, n3 = 0;
  int     s0c0 [2048];
  int     s0c1 [2048];
  int     s0zc [2048];
  longint s0t  [2048];
  int     s3v  [2048];
  longint s3t  [2048];
  int     b0, b3;

  task automatic chk(input string name, input longint got, input longint exp, input longint tol = 0);
    longint d;
    checks++;
    d = (got > exp) ? got - exp : exp - got;
    if (d > tol) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  function automatic int lut_exp(input int i);
    real v;
    v = 8191.0 * $sin(2.0 * 3.14159265358979 * i / 2048.0);
    return (v >= 0.0) ? 8192 + $rtoi(v + 0.5) : 8192 - $rtoi(0.5 - v);
  endfunction

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (reset_n) begin
      chk("zc0_without_valid", zc0 & ~dv0, 0);
      chk("zc3_without_valid", zc3 & ~dv3, 0);
    end
    if (dv0 && ready && n0 < 2048) begin
      s0c0[n0] = int'(d0[13:0]);
      s0c1[n0] = int'(d0[45:32]);
      s0zc[n0] = int'(zc0);
      s0t[n0]  = cyc;
      n0++;
    end
    if (dv3 && ready && n3 < 2048) begin
      s3v[n3] = int'(d3[13:0]);
      s3t[n3] = cyc;
      n3++;
    end
  end

  task automatic start_cfg(input logic [1:0] m, input logic [15:0] a,
                           input logic [31:0] inc, input logic [31:0] off1);
    @(posedge clock); #1;
    sync_rst  = 1'b1;
    mode      = m;
    amplitude = a;
    phase_inc = inc;
    phase_off = {off1, 32'h0};
    CE        = 1'b1;
    ready     = 1'b1;
    @(posedge clock); #1;
    sync_rst  = 1'b0;
    b0 = n0;
    b3 = n3;
  endtask

  task automatic wait_n0(input int base, input int n);
    int budget;
    budget = 0;
    while ((n0 - base) < n && budget < 5000) begin
      @(posedge clock);
      budget++;
    end
    chk("dut0_samples_in_time", int'((n0 - base) >= n), 1);
  endtask

  task automatic wait_n3(input int base, input int n);
    int budget;
    budget = 0;
    while ((n3 - base) < n && budget < 5000) begin
      @(posedge clock);
      budget++;
    end
    chk("dut3_samples_in_time", int'((n3 - base) >= n), 1);
  endtask

  task automatic measure_latency(input string name);
    int lat;
    lat = 0;
    while (!dv0 && lat < 10) begin
      @(posedge clock); #1;
      lat++;
    end
    chk(name, lat, 3);
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] amp;
    logic [31:0] inc;
    int          idx;
    int          exp;
    int          tol;
  } vec_t;

  localparam int NV = 25;
  vec_t vt [NV];

  initial begin
    logic [63:0] hold;
    logic        zhold;
    bit          have_cfg;
    logic [1:0]  cm;
    logic [15:0] ca;
    logic [31:0] ci;
    longint      t0;
    int          cnt;

    vt[0]  = '{2'd0, 16'h8000, 32'h0400_0000,  0,  8192, 0};
    vt[1]  = '{2'd0, 16'h8000, 32'h0400_0000,  1,  8995, 1};
    vt[2]  = '{2'd0, 16'h8000, 32'h0400_0000,  8, 13984, 1};
    vt[3]  = '{2'd0, 16'h8000, 32'h0400_0000, 16, 16383, 0};
    vt[4]  = '{2'd0, 16'h8000, 32'h0400_0000, 32,  8192, 0};
    vt[5]  = '{2'd0, 16'h8000, 32'h0400_0000, 48,     1, 0};
    vt[6]  = '{2'd1, 16'h1234, 32'h0400_0000,  0,  8192, 0};
    vt[7]  = '{2'd1, 16'h1234, 32'h0400_0000,  5,  8192, 0};
    vt[8]  = '{2'd2, 16'h8000, 32'h0400_0000,  3,   768, 0};
    vt[9]  = '{2'd2, 16'h8000, 32'h0400_0000, 48, 12288, 0};
    vt[10] = '{2'd2, 16'hC000, 32'h0400_0000,  3,     0, 0};
    vt[11] = '{2'd2, 16'hC000, 32'h0400_0000, 48, 14336, 0};
    vt[12] = '{2'd2, 16'hC000, 32'h0400_0000, 60, 16383, 0};
    vt[13] = '{2'd3, 16'h8000, 32'h0800_0000,  0, 16383, 0};
    vt[14] = '{2'd3, 16'h8000, 32'h0800_0000, 15, 16383, 0};
    vt[15] = '{2'd3, 16'h8000, 32'h0800_0000, 16,     0, 0};
    vt[16] = '{2'd3, 16'h8000, 32'h0800_0000, 31,     0, 0};
    vt[17] = '{2'd3, 16'h8000, 32'h0800_0000, 32, 16383, 0};
    vt[18] = '{2'd3, 16'h4000, 32'h0800_0000,  0, 12287, 0};
    vt[19] = '{2'd3, 16'h4000, 32'h0800_0000, 16,  4096, 0};
    vt[20] = '{2'd0, 16'hFFFF, 32'h0400_0000,  0,  8192, 0};
    vt[21] = '{2'd0, 16'hFFFF, 32'h0400_0000, 16, 16383, 0};
    vt[22] = '{2'd0, 16'hFFFF, 32'h0400_0000, 48,     0, 0};
    vt[23] = '{2'd0, 16'h0000, 32'h0400_0000, 16,  8192, 0};
    vt[24] = '{2'd0, 16'h0000, 32'h0400_0000, 48,  8192, 0};

    // Reset state
    #2 reset_n = 1'b0;
    #1;
    chk("rst_data_valid", dv0, 0);
    chk("rst_data", d0, 0);
    chk("rst_zero_cross", zc0, 0);
    chk("rst_data_valid_d3", dv3, 0);
    @(posedge clock); #1 reset_n = 1'b1;

    // Sine stream, 90-degree offset on ch1, stall in the middle
    start_cfg(2'd0, 16'h8000, 32'h0400_0000, 32'h4000_0000);
    measure_latency("first_latency");
    chk("first_ch0", d0[13:0], 8192);
    chk("first_ch1", d0[45:32], 16383);
    chk("first_zc", zc0, 1);
    chk("upper_bits_zero", d0[31:14], 0);
    wait_n0(b0, 20);
    chk("throughput", s0t[b0+10] - s0t[b0], 10);
    @(posedge clock); #1;
    ready = 1'b0;
    hold  = d0;
    zhold = zc0;
    chk("stall_valid_before", dv0, 1);
    repeat (5) begin
      @(negedge clock);
      chk("stall_data", d0, hold);
      chk("stall_valid", dv0, 1);
      chk("stall_zc", zc0, zhold);
    end
    @(posedge clock); #1 ready = 1'b1;
    wait_n0(b0, 140);
    for (int n = 0; n < 130; n++) begin
      chk($sformatf("seq_ch0[%0d]", n), s0c0[b0+n], lut_exp((32 * n) % 2048), 1);
      chk($sformatf("seq_ch1[%0d]", n), s0c1[b0+n], lut_exp((32 * n + 512) % 2048), 1);
      chk($sformatf("seq_zc[%0d]", n), s0zc[b0+n], ((n % 64) == 0) ? 1 : 0);
    end

    // Mode/amplitude vector table
    have_cfg = 1'b0;
    cm = '0; ca = '0; ci = '0;
    for (int i = 0; i < NV; i++) begin
      if (!have_cfg || vt[i].mode != cm || vt[i].amp != ca || vt[i].inc != ci) begin
        cm = vt[i].mode;
        ca = vt[i].amp;
        ci = vt[i].inc;
        start_cfg(cm, ca, ci, 32'h0);
        wait_n0(b0, 70);
        have_cfg = 1'b1;
      end
      chk($sformatf("vec%0d_ch0", i), s0c0[b0+vt[i].idx], vt[i].exp, vt[i].tol);
      chk($sformatf("vec%0d_ch1", i), s0c1[b0+vt[i].idx], vt[i].exp, vt[i].tol);
    end

    // sync_rst with a tick pending
    start_cfg(2'd0, 16'h8000, 32'h0400_0000, 32'h0);
    wait_n0(b0, 10);
    @(posedge clock); #1;
    hold     = d0;
    sync_rst = 1'b1;
    @(posedge clock); #1;
    chk("sync_valid", dv0, 0);
    chk("sync_zc", zc0, 0);
    chk("sync_data_hold", d0, hold);
    chk("sync_valid_d3", dv3, 0);
    sync_rst = 1'b0;
    b0 = n0;
    measure_latency("sync_restart_latency");
    wait_n0(b0, 1);
    chk("sync_restart_ch0", s0c0[b0], 8192);
    chk("sync_restart_zc", s0zc[b0], 1);

    // Async reset mid-burst
    wait_n0(b0, 10);
    @(posedge clock); #3;
    reset_n = 1'b0;
    #1;
    chk("async_valid", dv0, 0);
    chk("async_data", d0, 0);
    chk("async_zc", zc0, 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    b0 = n0;
    measure_latency("async_restart_latency");
    wait_n0(b0, 1);
    chk("async_restart_ch0", s0c0[b0], 8192);
    chk("async_restart_zc", s0zc[b0], 1);

    // DELAY=3 instance: spacing and CE gating
    start_cfg(2'd2, 16'h8000, 32'h0400_0000, 32'h0);
    wait_n3(b3, 4);
    for (int i = 1; i < 4; i++) begin
      chk($sformatf("d3_spacing[%0d]", i), s3t[b3+i] - s3t[b3+i-1], 4);
    end
    @(posedge clock); #1;
    CE = 1'b0;
    t0 = cyc;
    repeat (10) @(posedge clock);
    #1;
    cnt = 0;
    for (int i = b3; i < n3; i++) begin
      if (s3t[i] > t0 + 3) cnt++;
    end
    chk("d3_no_samples_ce_low", cnt, 0);
    CE = 1'b1;
    wait_n3(b3, 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("d3_ramp[%0d]", i), s3v[b3+i], 256 * i);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
